// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and pipe_stall_ctrl.
// master: the pipeline side. It drives the ID/EX instruction info, br_taken and mem_busy,
//         and receives the stall, flush and status signals.
// slave:  the controller side, which sees the same signals with the opposite directions.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      instr_dec;
  logic [15:0]      instr_ex;
  logic [1:0]       regdst_ex;
  logic             regWriteEn_ex;
  logic             br_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_dec, instr_ex, regdst_ex, regWriteEn_ex, br_taken, mem_busy,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble,
           halted, mem_err, stall_count
  );

  modport slave (
    input  instr_dec, instr_ex, regdst_ex, regWriteEn_ex, br_taken, mem_busy,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble,
           halted, mem_err, stall_count
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard scheduler. It inserts load-use bubbles, flushes IF/ID on a taken redirect,
// freezes the whole pipe while data memory is busy (with a watchdog), and parks the front end on HALT.
// Ports: clk, rst (async, active-low), bus (slave side of pipe_stall_ctrl_if).
// Latency: stall, flush and bubble are combinational from the state and the inputs, so there is no added cycle.
// Backpressure: mem_busy beats a redirect, which beats a load-use hazard. A redirect seen during a busy wait is remembered.
module pipe_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam int         WD_W    = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH, S_HALT} state_t;

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // ---------------- load-use detection ----------------
  logic [4:0] op_dec, op_ex;
  logic [2:0] ex_dest;
  logic       rs_used, rt_used, load_use;

  assign op_dec = bus.instr_dec[15:11];
  assign op_ex  = bus.instr_ex[15:11];

  always_comb begin
    ex_dest = bus.instr_ex[10:8];
    case (bus.regdst_ex)
      2'b00:   ex_dest = bus.instr_ex[4:2];
      2'b01:   ex_dest = bus.instr_ex[7:5];
      default: ex_dest = bus.instr_ex[10:8];
    endcase
  end

  assign rs_used = !(op_dec inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});
  assign rt_used = (op_dec[4:1] == 4'b1101) || (op_dec[4:2] == 3'b111) ||
                   (op_dec == OP_ST) || (op_dec == OP_STU);
  assign load_use = (op_ex == OP_LD) && bus.regWriteEn_ex && (bus.regdst_ex != 2'b11) &&
                    ((rs_used && (bus.instr_dec[10:8] == ex_dest)) ||
                     (rt_used && (bus.instr_dec[7:5] == ex_dest)));

  // ---------------- next state and controls ----------------
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;
  logic stall_all, redirect, run_eval;
  logic [WD_W-1:0] wd_inc;

  assign wd_inc = (wd_q == WD_W'(MEM_TIMEOUT)) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    stall_all     = 1'b0;
    redirect      = 1'b0;
    run_eval      = 1'b0;

    unique case (state_q)
      S_RUN: run_eval = 1'b1;
      S_MEM_WAIT: begin
        if (bus.mem_busy) begin
          stall_all    = 1'b1;
          wd_d         = wd_inc;
          flush_pend_d = flush_pend_q | bus.br_taken;
        end else begin
          wd_d         = '0;
          state_d      = S_RUN;
          flush_pend_d = 1'b0;
          // The remembered redirect takes this cycle. Otherwise the normal rules apply with no lost cycle.
          if (flush_pend_q) redirect = 1'b1;
          else              run_eval = 1'b1;
        end
      end
      S_FLUSH: begin
        // ID and EX hold bubbles here, so a redirect, load-use or HALT seen now is stale and ignored.
        if (bus.mem_busy) begin
          stall_all = 1'b1;
          wd_d      = wd_inc;
        end else begin
          wd_d         = '0;
          ifid_flush_c = 1'b1;
          if (cnt_q <= 3'd1) state_d = S_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      S_HALT: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    if (run_eval) begin
      if (bus.mem_busy) begin
        stall_all    = 1'b1;
        wd_d         = {{(WD_W-1){1'b0}}, 1'b1};
        flush_pend_d = bus.br_taken;
        state_d      = S_MEM_WAIT;
      end else if (bus.br_taken) begin
        redirect = 1'b1;
      end else begin
        if (load_use) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end
        if (op_ex == OP_HALT) state_d = S_HALT;
      end
    end

    if (redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = S_FLUSH;
        cnt_d   = 3'(FLUSH_CYCLES - 1);
      end else begin
        state_d = S_RUN;
      end
    end

    if (stall_all) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
    end
  end

  assign mem_err_d     = mem_err_q | (wd_d == WD_W'(MEM_TIMEOUT));
  assign stall_count_d = (pc_stall_c && (stall_count_q != '1)) ? stall_count_q + 1'b1 : stall_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RUN;
      flush_pend_q  <= 1'b0;
      cnt_q         <= '0;
      wd_q          <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_pend_q  <= flush_pend_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      mem_err_q     <= mem_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  // The combinational controls are gated so that every output is 0 while reset is held, whatever the inputs do.
  assign bus.pc_stall    = rst & pc_stall_c;
  assign bus.ifid_stall  = rst & ifid_stall_c;
  assign bus.idex_stall  = rst & stall_all;
  assign bus.exmem_stall = rst & stall_all;
  assign bus.ifid_flush  = rst & ifid_flush_c;
  assign bus.idex_bubble = rst & idex_bubble_c;
  assign bus.halted      = rst & (state_q == S_HALT);
  assign bus.mem_err     = rst & mem_err_q;
  assign bus.stall_count = stall_count_q & {CNT_W{rst}};

  logic unused_bits;
  assign unused_bits = ^{bus.instr_dec[4:0], bus.instr_ex[1:0]};
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
  localparam int FC = 3;
  localparam int MT = 64;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [15:0] I_NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_stall_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  wire [7:0] out_vec = {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
                        bus.ifid_flush, bus.idex_bubble, bus.halted, bus.mem_err};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: what the pipe should be doing, kept as plain counters.
  bit m_halt, m_err, m_pend;
  int m_flush_left, m_busy_len, m_stalls;
  logic [7:0] obs;

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_pend = 0;
    m_flush_left = 0; m_busy_len = 0; m_stalls = 0;
  endtask

  // Does the ID instruction read the register that the EX load is writing?
  function automatic bit hazard(input logic [15:0] idec, input logic [15:0] iex,
                                input logic [1:0] rd, input logic we);
    logic [4:0] od;
    logic [2:0] dst;
    bit reads_rs, reads_rt;
    if (iex[15:11] != 5'b10001 || !we || rd == 2'b11) return 0;
    dst = (rd == 2'd0) ? iex[4:2] : (rd == 2'd1) ? iex[7:5] : iex[10:8];
    od = idec[15:11];
    reads_rs = 1;
    if (od == 5'd0 || od == 5'd1 || od == 5'd4 || od == 5'd6 || od == 5'd24) reads_rs = 0;
    reads_rt = (od == 5'd26 || od == 5'd27 || od >= 5'd28 || od == 5'd16 || od == 5'd19);
    return (reads_rs && idec[10:8] == dst) || (reads_rt && idec[7:5] == dst);
  endfunction

  task automatic set_idle();
    bus.instr_dec = I_NOP; bus.instr_ex = I_NOP; bus.regdst_ex = 2'b11;
    bus.regWriteEn_ex = 0; bus.br_taken = 0; bus.mem_busy = 0;
  endtask

  task automatic step(input string tag, input logic [15:0] idec, input logic [15:0] iex,
                      input logic [1:0] rd, input logic we, input logic br, input logic busy);
    bit ps, is_, xs, ms, ff, bb, lu;
    @(posedge clk); #1;
    bus.instr_dec = idec; bus.instr_ex = iex; bus.regdst_ex = rd;
    bus.regWriteEn_ex = we; bus.br_taken = br; bus.mem_busy = busy;
    lu = hazard(idec, iex, rd, we);
    ps = 0; is_ = 0; xs = 0; ms = 0; ff = 0; bb = 0;
    if (m_halt) begin ps = 1; ff = 1; end
    else if (busy) begin ps = 1; is_ = 1; xs = 1; ms = 1; end
    else if (m_flush_left > 0) ff = 1;
    else if (m_pend || br) begin ff = 1; bb = 1; end
    else if (lu) begin ps = 1; is_ = 1; bb = 1; end
    @(negedge clk);
    obs = out_vec;
    check({tag, "/ctl"}, 32'(obs), 32'({ps, is_, xs, ms, ff, bb, m_halt, m_err}));
    check({tag, "/cnt"}, 32'(bus.stall_count), 32'(m_stalls));
    if (!m_halt) begin
      if (busy) begin
        m_busy_len++;
        if (m_flush_left == 0) m_pend = m_pend | br;
      end else begin
        m_busy_len = 0;
        if (m_flush_left > 0) m_flush_left--;
        else if (m_pend || br) begin m_pend = 0; m_flush_left = FC - 1; end
        else if (iex[15:11] == 5'b00000) m_halt = 1;
      end
      if (m_busy_len >= MT) m_err = 1;
    end
    if (ps && m_stalls < CNT_MAX) m_stalls++;
  endtask

  // Reset is asserted mid-cycle with busy/redirect/load-use activity on the inputs. Every output must drop at once.
  task automatic do_reset();
    #2;
    rst = 0;
    bus.mem_busy = 1; bus.br_taken = 1;
    bus.instr_ex = 16'h8900; bus.instr_dec = 16'hD900; bus.regdst_ex = 2'b10; bus.regWriteEn_ex = 1;
    #1;
    check("reset_outputs", {23'd0, out_vec, 1'b0} | 32'(bus.stall_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    set_idle();
    rst = 1;
    model_reset();
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op);
    logic [10:0] r;
    r = 11'($urandom) & 11'b011_011_011_11;
    return {op, r};
  endfunction

  initial begin
    logic [4:0] dec_ops [10];
    logic [4:0] ex_ops  [6];
    logic [15:0] ld_r1, add_r1;
    int burst;
    logic [4:0] eop;
    dec_ops = '{5'b11011, 5'b11100, 5'b11000, 5'b10000, 5'b10011,
                5'b00001, 5'b00100, 5'b00110, 5'b11010, 5'b01000};
    ex_ops  = '{5'b10001, 5'b10001, 5'b10001, 5'b11011, 5'b10000, 5'b00100};
    rst = 1;
    set_idle();
    model_reset();
    do_reset();

    // A load-use hazard gives exactly one bubble. An LBI in ID reads nothing, so it does not stall.
    ld_r1  = {5'b10001, 3'd1, 8'h00};
    add_r1 = {5'b11011, 3'd1, 3'd2, 3'd3, 2'b00};
    step("ld_add", add_r1, ld_r1, 2'b10, 1, 0, 0);
    check("ld_add_bubble", 32'(obs), 32'h0C4);
    step("after_ld", add_r1, I_NOP, 2'b11, 0, 0, 0);
    check("after_ld_clean", 32'(obs), 32'h000);
    step("ld_lbi", {5'b11000, 3'd1, 8'h00}, ld_r1, 2'b10, 1, 0, 0);
    check("ld_lbi_nostall", 32'(obs), 32'h000);

    // With FLUSH_CYCLES=3 a redirect flushes IF/ID for 3 cycles and bubbles ID/EX only in the first.
    step("br0", I_NOP, I_NOP, 2'b11, 0, 1, 0);
    check("br_first", 32'(obs), 32'h00C);
    step("br1", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("br_second", 32'(obs), 32'h008);
    step("br2", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("br_third", 32'(obs), 32'h008);
    step("br3", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("br_done", 32'(obs), 32'h000);

    // Memory is busy for 5 cycles and a redirect arrives in cycle 2. The flush follows in cycle 6.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step("mb5", I_NOP, I_NOP, 2'b11, 0, (i == 2), 1);
      check("mb5_stall", 32'(obs), 32'h0F0);
    end
    step("mb5_flush", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("mb5_flush_c6", 32'(obs), 32'h00C);
    step("mb5_f2", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    step("mb5_f3", I_NOP, I_NOP, 2'b11, 0, 0, 0);

    // Memory is busy for 70 cycles. The watchdog trips after 64 and stays set. stall_count saturates.
    for (int i = 1; i <= 70; i++) begin
      step("mb70", I_NOP, I_NOP, 2'b11, 0, 0, 1);
      if (i == 64) check("mem_err_c64", 32'(obs[0]), 32'd0);
      if (i == 65) check("mem_err_c65", 32'(obs[0]), 32'd1);
    end
    step("mb70_end", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("mem_err_sticky", 32'(obs), 32'h001);
    check("stall_sat", 32'(bus.stall_count), 32'(CNT_MAX));

    // HALT retires from EX and parks the front end. Reset is the only exit.
    do_reset();
    step("halt_in", I_NOP, 16'h0000, 2'b11, 0, 0, 0);
    step("halted", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("halted_next", 32'(obs), 32'h08A);
    step("halt_hold", add_r1, ld_r1, 2'b10, 1, 1, 0);
    do_reset();
    step("post_halt", I_NOP, I_NOP, 2'b11, 0, 0, 0);
    check("run_after_rst", 32'(obs), 32'h000);

    // Random traffic is checked against the model. Long busy bursts sometimes trip the watchdog.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      burst = 0;
      for (int c = 0; c < 160; c++) begin
        logic busy;
        if (burst == 0 && $urandom_range(0, 7) == 0)
          burst = ($urandom_range(0, 39) == 0) ? 66 : int'($urandom_range(1, 6));
        busy = (burst > 0);
        if (burst > 0) burst--;
        eop = ($urandom_range(0, 79) == 0) ? 5'b00000 : ex_ops[$urandom_range(0, 5)];
        step("rand", mk(dec_ops[$urandom_range(0, 9)]), mk(eop), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), busy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
